dvs_event_reader: RTL and testbench

- Consumer side of the DVS line-buffer protocol.
- After the PS has DMA'd a processed 128x128 difference frame back into the BRAM line buffer, one line at a time, this block does three things:
  - requests each line;
  - reads its 64 packed 32-bit words;
  - unpacks two pixels per word and emits one (x, y, polarity) event per changed pixel on a valid/ready stream.
- It sits between the BRAM controller port and the downstream event sink (AER/UART/FIFO).

---
 rtl/dvs_event_reader.sv | 139 +++++++++++++
 tb/tb_dvs_event_reader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvs_event_reader.sv
// dvs_event_reader: walks every line of a processed difference frame in the BRAM line buffer
// and turns each changed pixel into an (x, y, polarity) event on a valid/ready stream.
module dvs_event_reader #(
    parameter int LINE_WORDS = 64,
    parameter int NUM_LINES  = 128,
    parameter int ADDR_W     = 17
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              frame_start,
    output logic              line_req,
    output logic [6:0]        req_line,
    input  logic              line_ready,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_clk,
    output logic              bram_en,
    output logic              bram_rst,
    output logic [3:0]        bram_we,
    input  logic [31:0]       bram_rddata,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [6:0]        ev_x,
    output logic [6:0]        ev_y,
    output logic              ev_pol,
    output logic              frame_done,
    output logic [14:0]       frame_events,
    output logic              bad_code,
    output logic              busy
);
    typedef enum logic [3:0] {IDLE, REQ, WAIT_LINE, RD_ADDR, RD_WAIT, EMIT0, EMIT1, NEXT, DONE} state_t;

    state_t              state_q, state_d;
    logic [6:0]          y_q, y_d, req_line_q, req_line_d;
    logic [5:0]          w_q, w_d;
    logic [14:0]         cnt_q, cnt_d, events_q, events_d;
    logic [31:0]         word_q, word_d;
    logic                bad_q, bad_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                start, emit1;
    logic [1:0]          code;

    assign start        = frame_start && enable;
    assign emit1        = state_q == EMIT1;
    assign code         = emit1 ? word_q[7:6] : word_q[23:22];
    assign ev_valid     = (state_q == EMIT0 || emit1) && (code == 2'b01 || code == 2'b10);
    assign ev_x         = {w_q, emit1};
    assign ev_y         = y_q;
    assign ev_pol       = code == 2'b01;
    assign line_req     = state_q == REQ;
    assign frame_done   = state_q == DONE;
    assign busy         = state_q != IDLE;
    assign req_line     = req_line_q;
    assign bram_addr    = addr_q;
    assign frame_events = events_q;
    assign bad_code     = bad_q;
    assign bram_clk     = pclk;
    assign bram_en      = reset;
    assign bram_rst     = !reset;
    assign bram_we      = 4'b0000;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            y_q        <= '0;
            w_q        <= '0;
            cnt_q      <= '0;
            events_q   <= '0;
            word_q     <= '0;
            bad_q      <= 1'b0;
            req_line_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            w_q        <= w_d;
            cnt_q      <= cnt_d;
            events_q   <= events_d;
            word_q     <= word_d;
            bad_q      <= bad_d;
            req_line_q <= req_line_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        w_d      = w_q;
        cnt_d    = cnt_q;
        events_d = events_q;
        word_d   = word_q;
        bad_d    = bad_q;
        // An accepted frame_start restarts from line 0 in every state, aborting any frame in flight.
        if (start) begin
            state_d = REQ;
            y_d     = '0;
            cnt_d   = '0;
            bad_d   = 1'b0;
        end else begin
            case (state_q)
                REQ:       state_d = WAIT_LINE;
                WAIT_LINE: if (line_ready) begin
                    w_d     = '0;
                    state_d = RD_ADDR;
                end
                RD_ADDR:   state_d = RD_WAIT;
                RD_WAIT: begin
                    word_d  = bram_rddata;
                    state_d = EMIT0;
                end
                EMIT0, EMIT1: begin
                    bad_d = bad_q || code == 2'b11;
                    cnt_d = cnt_q + 15'(ev_valid && ev_ready);
                    if (!ev_valid || ev_ready) state_d = emit1 ? NEXT : EMIT1;
                end
                NEXT: begin
                    if (w_q != 6'(LINE_WORDS - 1)) begin
                        w_d     = w_q + 6'd1;
                        state_d = RD_ADDR;
                    end else if (y_q != 7'(NUM_LINES - 1)) begin
                        y_d     = y_q + 7'd1;
                        state_d = REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    events_d = cnt_q;
                    state_d  = IDLE;
                end
                default: ;
            endcase
        end
        // Line and address registers load only on entry so they stay put while the state waits.
        req_line_d = state_d == REQ ? y_d : req_line_q;
        addr_d     = state_d == RD_ADDR ? ADDR_W'(w_d) : addr_q;
    end
endmodule

// File: tb/tb_dvs_event_reader.sv
// tb_dvs_event_reader: random and directed frames on a reduced-size reader; expected events come
// from a raster scan of the frame image and are matched by a stream monitor.
module tb_dvs_event_reader;
    localparam int LW = 8;
    localparam int NL = 8;
    localparam int AW = 17;

    logic          pclk = 0, reset = 0, enable = 0, frame_start = 0, line_ready = 0, ev_ready = 0;
    logic [31:0]   bram_rddata = '0;
    logic          line_req, bram_clk, bram_en, bram_rst, ev_valid, ev_pol, frame_done, bad_code, busy;
    logic [6:0]    req_line, ev_x, ev_y;
    logic [AW-1:0] bram_addr;
    logic [3:0]    bram_we;
    logic [14:0]   frame_events;

    dvs_event_reader #(.LINE_WORDS(LW), .NUM_LINES(NL), .ADDR_W(AW)) dut (
        .pclk(pclk), .reset(reset), .enable(enable), .frame_start(frame_start),
        .line_req(line_req), .req_line(req_line), .line_ready(line_ready),
        .bram_addr(bram_addr), .bram_clk(bram_clk), .bram_en(bram_en), .bram_rst(bram_rst),
        .bram_we(bram_we), .bram_rddata(bram_rddata), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_x(ev_x), .ev_y(ev_y), .ev_pol(ev_pol), .frame_done(frame_done),
        .frame_events(frame_events), .bad_code(bad_code), .busy(busy)
    );

    always #5 pclk = ~pclk;

    int          checks = 0, failures = 0;
    logic [31:0] mem [NL][LW];
    int          exp_q[$];
    int          exp_cnt, exp_line = 0, buf_line = 0, ready_mode = 0, done_cnt = 0, stall = 0, d0 = 0;
    bit          exp_bad, aborting = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] rcode(int pe, int pb);
        int r = $urandom_range(0, 99);
        return r < pe ? 2'($urandom_range(1, 2)) : r < pe + pb ? 2'b11 : 2'b00;
    endfunction

    task automatic fill(int pe, int pb);
        for (int y = 0; y < NL; y++)
            for (int w = 0; w < LW; w++)
                mem[y][w] = {8'($urandom), rcode(pe, pb), 6'($urandom), 8'($urandom), rcode(pe, pb), 6'($urandom)};
    endtask

    task automatic fill_const(logic [31:0] v);
        for (int y = 0; y < NL; y++)
            for (int w = 0; w < LW; w++) mem[y][w] = v;
    endtask

    // Raster scan of the whole image: one event per pixel whose code is 01 or 10.
    task automatic load_expected();
        logic [31:0] wd;
        logic [1:0]  c;
        exp_q.delete();
        exp_cnt = 0;
        exp_bad = 0;
        for (int y = 0; y < NL; y++)
            for (int x = 0; x < 2 * LW; x++) begin
                wd = mem[y][x / 2];
                c  = (x % 2 == 0) ? wd[23:22] : wd[7:6];
                if (c == 2'b01 || c == 2'b10) begin
                    exp_q.push_back(x | (y << 7) | (int'(c == 2'b01) << 14));
                    exp_cnt++;
                end else if (c == 2'b11) exp_bad = 1;
            end
    endtask

    initial begin
        int a;
        forever begin
            @(negedge pclk);
            a = int'(bram_addr);
            @(posedge pclk);
            #1 bram_rddata = mem[buf_line][a % LW];
        end
    end

    initial begin
        int pend = 0;
        forever begin
            @(posedge pclk);
            #1 line_ready = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    line_ready = 1;
                    buf_line   = int'(req_line);
                end
            end
            if (line_req) begin
                chk("req_line", 32'(req_line), exp_line);
                exp_line++;
                pend = $urandom_range(1, 4);
            end
        end
    end

    initial forever begin
        @(posedge pclk);
        #1 ev_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) :
                      ready_mode == 2 ? (stall >= 10) : 1'b0;
    end

    initial begin
        bit          have_prev = 0;
        logic [31:0] cur, prev = 0;
        forever begin
            @(negedge pclk);
            if (frame_done) done_cnt++;
            cur = {17'b0, ev_pol, ev_y, ev_x};
            if (aborting || !reset) begin
                have_prev = 0;
                stall     = 0;
            end else if (ev_valid) begin
                if (have_prev) chk("payload_stable", cur, prev);
                if (ev_ready) begin
                    if (ready_mode == 2) chk("stall_len", stall, 10);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_event got=%0h with empty queue", cur);
                    end else chk("event", cur, exp_q.pop_front());
                    have_prev = 0;
                    stall     = 0;
                end else begin
                    have_prev = 1;
                    prev      = cur;
                    stall++;
                end
            end else begin
                if (have_prev) chk("valid_held", 32'(ev_valid), 1);
                have_prev = 0;
            end
        end
    end

    task automatic start_frame();
        d0       = done_cnt;
        exp_line = 0;
        @(posedge pclk);
        #1 enable = 1;
        frame_start = 1;
        @(posedge pclk);
        #1 frame_start = 0;
        @(negedge pclk);
        chk("busy_after_start", 32'(busy), 1);
        chk("bad_cleared", 32'(bad_code), 0);
    endtask

    task automatic finish_frame();
        bit seen = 0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge pclk);
            seen = frame_done;
        end
        if (!seen) begin
            failures++;
            $display("FAIL frame_done_timeout actual=0 expected=1");
        end
        @(negedge pclk);
        chk("frame_events", 32'(frame_events), exp_cnt);
        chk("bad_code", 32'(bad_code), 32'(exp_bad));
        chk("events_left", exp_q.size(), 0);
        chk("line_reqs", exp_line, NL);
        chk("done_pulse_len", 32'(frame_done), 0);
        chk("idle_after_done", 32'(busy), 0);
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        int prev_ev;
        bit seen;
        #12;
        chk("rst_ev_valid", 32'(ev_valid), 0);
        chk("rst_line_req", 32'(line_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_events", 32'(frame_events), 0);
        chk("rst_bram_addr", 32'(bram_addr), 0);
        chk("rst_req_line", 32'(req_line), 0);
        chk("rst_bad_code", 32'(bad_code), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_bram_en", 32'(bram_en), 0);
        chk("rst_bram_rst", 32'(bram_rst), 1);
        @(negedge pclk) reset = 1;
        #1;
        chk("bram_en", 32'(bram_en), 1);
        chk("bram_rst", 32'(bram_rst), 0);
        chk("bram_we", 32'(bram_we), 0);

        @(posedge pclk);
        #1 frame_start = 1;
        @(posedge pclk);
        #1 frame_start = 0;
        @(negedge pclk);
        chk("start_ignored_disabled", 32'(busy), 0);

        fill_const(32'h0);
        load_expected();
        start_frame();
        finish_frame();

        for (int m = 0; m < 2; m++) begin
            fill_const(32'h0);
            mem[5][3] = 32'h00400080;
            load_expected();
            ready_mode = m == 0 ? 0 : 2;
            start_frame();
            finish_frame();
        end

        fill_const(32'h00400040);
        load_expected();
        ready_mode = 0;
        start_frame();
        finish_frame();

        for (int f = 0; f < 6; f++) begin
            fill(30, f % 2 ? 10 : 0);
            load_expected();
            ready_mode = f % 3 == 2 ? 2 : f % 3;
            start_frame();
            finish_frame();
        end

        fill(20, 0);
        mem[2][4][23:22] = 2'b11;
        load_expected();
        ready_mode = 1;
        start_frame();
        repeat (20) @(posedge pclk);
        #1 enable = 0;
        frame_start = 1;
        @(posedge pclk);
        #1 frame_start = 0;
        finish_frame();

        fill(30, 0);
        mem[4][1] = 32'h00400040;
        load_expected();
        ready_mode = 1;
        prev_ev = int'(frame_events);
        start_frame();
        seen = 0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge pclk);
            seen = buf_line == 4;
        end
        ready_mode = 3;
        @(posedge pclk);
        seen = 0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge pclk);
            seen = ev_valid && buf_line >= 4;
        end
        chk("abort_reached_event", 32'(seen), 1);
        @(posedge pclk);
        #1 frame_start = 1;
        aborting = 1;
        load_expected();
        exp_line = 0;
        @(posedge pclk);
        #1 frame_start = 0;
        ready_mode = 1;
        @(negedge pclk);
        chk("abort_valid_drop", 32'(ev_valid), 0);
        chk("abort_line_req", 32'(line_req), 1);
        chk("abort_frame_events", 32'(frame_events), prev_ev);
        @(posedge pclk);
        #1 aborting = 0;
        finish_frame();

        fill(40, 0);
        load_expected();
        start_frame();
        repeat (100) @(posedge pclk);
        #3 aborting = 1;
        reset = 0;
        #1;
        chk("areset_busy", 32'(busy), 0);
        chk("areset_ev_valid", 32'(ev_valid), 0);
        chk("areset_line_req", 32'(line_req), 0);
        chk("areset_frame_events", 32'(frame_events), 0);
        chk("areset_bram_addr", 32'(bram_addr), 0);
        @(negedge pclk) reset = 1;
        @(posedge pclk);
        #1 aborting = 0;

        fill(30, 0);
        load_expected();
        start_frame();
        finish_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
